// File: rtl/shfifo_pkg.sv
// Shared constants and helpers for the show-ahead FIFO controller.
package shfifo_pkg;

  localparam int unsigned RAM_RD_LAT = 2;
  localparam int unsigned PF_DEPTH   = RAM_RD_LAT + 1;

  // Modular pointer difference over a ptr_w-bit pointer space.
  function automatic logic [31:0] ptr_diff(input logic [31:0] wp,
                                           input logic [31:0] rp,
                                           input int unsigned ptr_w);
    logic [31:0] mask;
    mask = (32'd1 << ptr_w) - 32'd1;
    return (wp - rp) & mask;
  endfunction

endpackage

// File: rtl/shfifo_pf_buf.sv
// Small register FIFO holding words already read from RAM; entry 0 is the head.
module shfifo_pf_buf
  import shfifo_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = PF_DEPTH,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  cnt,
  output logic              empty
);

  logic [DATA_W-1:0] ent [DEPTH];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  wr_idx;

  // A simultaneous pop shifts everything down, so the new word lands one slot lower.
  always_comb begin
    wr_idx = cnt_q;
    if (pop) wr_idx = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
      cnt_q <= '0;
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) ent[i] <= ent[i+1];
        ent[DEPTH-1] <= '0;
      end
      if (push && (wr_idx < CNT_W'(DEPTH))) ent[wr_idx] <= din;
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head  = ent[0];
  assign cnt   = cnt_q;
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/shfifo_ctrl.sv
// Show-ahead FIFO controller driving a 2-cycle-latency simple dual-port RAM,
// with a prefetch buffer so the head word is always presented while non-empty.
module shfifo_ctrl
  import shfifo_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                full,
  input  logic                rd_en,
  output logic [DATA_W-1:0]   rd_data,
  output logic                empty,
  output logic [ADDR_W+1:0]   count,
  output logic                ovf,
  output logic                udf,
  output logic                ram_wen,
  output logic [ADDR_W-1:0]   ram_waddr,
  output logic [DATA_W-1:0]   ram_wdat,
  output logic                ram_ren,
  output logic [ADDR_W-1:0]   ram_raddr,
  input  logic [DATA_W-1:0]   ram_q
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_W;
  localparam int unsigned PTR_W     = ADDR_W + 1;
  localparam int unsigned CNT_W     = ADDR_W + 2;
  localparam int unsigned PFC_W     = $clog2(PF_DEPTH + 1);
  localparam int unsigned RESV_W    = PFC_W + 1;

  logic [PTR_W-1:0]      wptr, rptr, ram_occ, wr_occ;
  logic [RAM_RD_LAT-1:0] infl;
  logic [PFC_W-1:0]      pf_cnt;
  logic [RESV_W-1:0]     resv;
  logic [CNT_W-1:0]      count_q;
  logic                  push, pop, pf_wr, pf_empty;
  logic                  ovf_q, udf_q;

  assign wr_occ = PTR_W'(ptr_diff(32'(wptr), 32'(rptr), PTR_W));
  assign full   = (wr_occ == PTR_W'(RAM_DEPTH));
  assign empty  = pf_empty;
  assign push   = wr_en & ~full;
  assign pop    = rd_en & ~pf_empty;
  assign pf_wr  = infl[RAM_RD_LAT-1];

  // Prefetch slots already spoken for: held words plus reads still in flight.
  always_comb begin
    resv = RESV_W'(pf_cnt);
    for (int unsigned i = 0; i < RAM_RD_LAT; i++) resv = resv + RESV_W'(infl[i]);
    resv = resv - RESV_W'(pop);
  end

  assign ram_ren   = (ram_occ != '0) && (resv < RESV_W'(PF_DEPTH));
  assign ram_raddr = rptr[ADDR_W-1:0];
  assign ram_wen   = push;
  assign ram_waddr = wptr[ADDR_W-1:0];
  assign ram_wdat  = wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_occ <= '0;
      infl    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr    <= wptr + PTR_W'(push);
      rptr    <= rptr + PTR_W'(ram_ren);
      ram_occ <= ram_occ + PTR_W'(push) - PTR_W'(ram_ren);
      infl    <= {infl[RAM_RD_LAT-2:0], ram_ren};
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      ovf_q   <= wr_en & full;
      udf_q   <= rd_en & pf_empty;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

  shfifo_pf_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (PF_DEPTH)
  ) u_pf_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (pf_wr),
    .din   (ram_q),
    .pop   (pop),
    .head  (rd_data),
    .cnt   (pf_cnt),
    .empty (pf_empty)
  );

endmodule

// File: tb/tb_shfifo_ctrl.sv
// Directed bench for shfifo_ctrl with a behavioural 2-cycle-latency RAM alongside.
module tb_shfifo_ctrl;

  logic        clk, rst;
  logic        wr_en, rd_en;
  logic [31:0] wr_data, rd_data, ram_wdat, ram_q;
  logic        full, empty, ovf, udf, ram_wen, ram_ren;
  logic [4:0]  count;
  logic [2:0]  ram_waddr, ram_raddr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  shfifo_ctrl #(.DATA_W(32), .ADDR_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .count     (count),
    .ovf       (ovf),
    .udf       (udf),
    .ram_wen   (ram_wen),
    .ram_waddr (ram_waddr),
    .ram_wdat  (ram_wdat),
    .ram_ren   (ram_ren),
    .ram_raddr (ram_raddr),
    .ram_q     (ram_q)
  );

  // RAM model: inputs registered, write one cycle later, q two cycles after ren.
  logic [31:0] mem [8];
  logic        wen_r, ren_r;
  logic [2:0]  waddr_r, raddr_r;
  logic [31:0] wdat_r;

  always @(posedge clk) begin
    wen_r   <= ram_wen;
    waddr_r <= ram_waddr;
    wdat_r  <= ram_wdat;
    if (wen_r) mem[waddr_r] <= wdat_r;
    ren_r   <= ram_ren;
    raddr_r <= ram_raddr;
    if (ren_r) ram_q <= mem[raddr_r];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int unsigned n;
    n = 0;
    while (empty && n < 12) begin
      step();
      n++;
    end
    check({tag, "_ready"}, 32'(empty), 32'd0);
  endtask

  task automatic pop_one(input string tag, input logic [31:0] exp);
    wait_ready(tag);
    check(tag, rd_data, exp);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    int unsigned pushed, popped, cyc;
    bit started;

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    step();
    step();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_udf", 32'(udf), 32'd0);
    check("rst_wen", 32'(ram_wen), 32'd0);
    check("rst_ren", 32'(ram_ren), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    rst = 1'b0;

    // Underflow on an empty FIFO
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("udf_pulse", 32'(udf), 32'd1);
    check("udf_count", 32'(count), 32'd0);
    check("udf_rd_data", rd_data, 32'd0);
    check("udf_empty", 32'(empty), 32'd1);
    step();
    check("udf_clear", 32'(udf), 32'd0);

    // Single word latency: push cycle 0, ren cycle 1, visible cycle 4
    wr_en = 1'b1; wr_data = 32'hA5A5_0001;
    #1;
    check("sw_wen", 32'(ram_wen), 32'd1);
    check("sw_waddr", 32'(ram_waddr), 32'd0);
    step();
    wr_en = 1'b0;
    #1;
    check("sw_ren_c1", 32'(ram_ren), 32'd1);
    check("sw_raddr_c1", 32'(ram_raddr), 32'd0);
    step();
    check("sw_empty_c2", 32'(empty), 32'd1);
    step();
    check("sw_empty_c3", 32'(empty), 32'd1);
    check("sw_ram_q_c3", ram_q, 32'hA5A5_0001);
    step();
    check("sw_empty_c4", 32'(empty), 32'd0);
    check("sw_data_c4", rd_data, 32'hA5A5_0001);
    check("sw_count_c4", 32'(count), 32'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("sw_empty_pop", 32'(empty), 32'd1);
    check("sw_count_pop", 32'(count), 32'd0);

    // Fill to 11 words, then an overflow attempt
    for (int i = 0; i < 11; i++) begin
      if (i == 10) check("fill_not_full", 32'(full), 32'd0);
      wr_en = 1'b1; wr_data = 32'h100 + 32'(i);
      step();
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd11);
    wr_data = 32'hDEAD_BEEF;
    #1;
    check("ovf_no_wen", 32'(ram_wen), 32'd0);
    step();
    wr_en = 1'b0;
    check("ovf_pulse", 32'(ovf), 32'd1);
    check("ovf_count", 32'(count), 32'd11);
    step();
    check("ovf_clear", 32'(ovf), 32'd0);
    for (int i = 0; i < 11; i++) pop_one("fill_drain", 32'h100 + 32'(i));
    check("fill_empty", 32'(empty), 32'd1);
    check("fill_count0", 32'(count), 32'd0);
    check("fill_not_full_end", 32'(full), 32'd0);

    // Streaming: push every cycle, pop whenever a word is presented
    pushed = 0; popped = 0; cyc = 0; started = 1'b0;
    while (popped < 100 && cyc < 300) begin
      wr_en   = (pushed < 100);
      wr_data = 32'h5000_0000 + pushed;
      rd_en   = !empty;
      if (rd_en) begin
        check("strm_data", rd_data, 32'h5000_0000 + popped);
        popped++;
        started = 1'b1;
      end
      if (started && pushed < 100) begin
        check("strm_bubble", 32'(empty), 32'd0);
        check("strm_count", 32'(count), 32'd4);
      end
      check("strm_ovf", 32'(ovf), 32'd0);
      check("strm_udf", 32'(udf), 32'd0);
      if (wr_en) pushed++;
      step();
      cyc++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    check("strm_popped", popped, 32'd100);
    check("strm_empty", 32'(empty), 32'd1);
    check("strm_count0", 32'(count), 32'd0);

    // Wrap-around: repeated fill/drain of 8 words
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        wr_en = 1'b1; wr_data = 32'hC000_0000 | (32'(r) << 8) | 32'(i);
        step();
      end
      wr_en = 1'b0;
      check("wrap_count", 32'(count), 32'd8);
      for (int i = 0; i < 8; i++) pop_one("wrap_data", 32'hC000_0000 | (32'(r) << 8) | 32'(i));
      check("wrap_empty", 32'(empty), 32'd1);
    end

    // Reset while reads are in flight
    wr_en = 1'b1; wr_data = 32'hBEEF_0000;
    step();
    wr_data = 32'hBEEF_0001;
    step();
    wr_en = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("mrst_empty", 32'(empty), 32'd1);
    check("mrst_count", 32'(count), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("mrst_no_stale", 32'(empty), 32'd1);
    wr_en = 1'b1; wr_data = 32'h0000_1234;
    step();
    wr_en = 1'b0;
    wait_ready("mrst_new");
    check("mrst_count1", 32'(count), 32'd1);
    pop_one("mrst_data", 32'h0000_1234);
    for (int i = 0; i < 4; i++) step();
    check("mrst_empty_end", 32'(empty), 32'd1);
    check("mrst_count_end", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shfifo_ctrl.md
Name: shfifo_ctrl

Overview:
- Show-ahead (first-word-fall-through) synchronous FIFO controller that drives the write and read ports of the sdp_ram block directly.
- Owns the pointers, occupancy and flags, and tracks the RAM's 2-cycle read latency.
- Holds prefetched words in a 3-entry output buffer, so the head word is always presented on rd_data while empty is low.
- Sustains one push and one pop per cycle.

Parameters:
- DATA_W, 32, word width; must equal the RAM data width.
- ADDR_W, 3, RAM address width; RAM_DEPTH = 2^ADDR_W; ADDR_W >= 2.
- PF_DEPTH, 3, prefetch buffer entries (RAM latency 2 + 1); fixed, not user-tunable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  push request.
- wr_data  in  DATA_W  push data.
- full  out  1  RAM occupancy == RAM_DEPTH.
- rd_en  in  1  pop request; acknowledges the current rd_data.
- rd_data  out  DATA_W  head word; valid while empty==0.
- empty  out  1  prefetch buffer empty.
- count  out  ADDR_W+2  total words held (RAM + in flight + prefetch).
- ovf  out  1  one-cycle pulse: wr_en while full.
- udf  out  1  one-cycle pulse: rd_en while empty.
- ram_wen  out  1  to RAM wen.
- ram_waddr  out  ADDR_W  to RAM waddr.
- ram_wdat  out  DATA_W  to RAM wdat.
- ram_ren  out  1  to RAM ren.
- ram_raddr  out  ADDR_W  to RAM raddr.
- ram_q  in  DATA_W  from RAM q.

Behaviour:
- RAM contract:
  - ram_wen at cycle t updates memory at the end of t+1.
  - ram_ren at cycle t gives valid ram_q in cycle t+2.
  - A read issued at cycle r must target only entries whose ram_wen was at cycle <= r-1. Same-cycle write/read of one address returns stale data and is forbidden.
- Push: push = wr_en & ~full.
  - ram_wen = push, ram_waddr = wptr, ram_wdat = wr_data (all combinational; the RAM registers them).
  - wptr increments on push and wraps at RAM_DEPTH.
- Committed occupancy: ram_occ counts entries written in an earlier cycle. Increments one cycle after push; decrements on ram_ren. full compares the uncommitted occupancy (wptr - rptr, ADDR_W+1 bits) against RAM_DEPTH.
- Read issue: ram_ren = (ram_occ > 0) & (pf_cnt + inflight - pop < PF_DEPTH).
  - ram_raddr = rptr; rptr increments on ram_ren and wraps.
- In-flight tracking: 2-stage shift register of ram_ren. When stage 2 is set, ram_q is written into the prefetch buffer at that clock edge.
- Pop: pop = rd_en & ~empty; removes the prefetch head. rd_data = prefetch head, registered.
- Underflow and overflow:
  - rd_en while empty is ignored and pulses udf.
  - wr_en while full is ignored and pulses ovf. The RAM is not written.
- count: +1 on push, -1 on pop, both on the same cycle gives no change.
  - Max count = RAM_DEPTH + PF_DEPTH (11 at defaults).
- Latency: push at cycle 0 into an idle FIFO gives ram_ren in cycle 1, ram_q in cycle 3, and empty=0 with the data valid in cycle 4.
- Throughput: with continuous push and pop, one word per cycle with no bubbles after the first-word latency.
- Simultaneous events:
  - Push while full with a same-cycle pop: still rejected. full depends on RAM occupancy only.
  - Prefetch write and pop in the same cycle are both performed.
- Reset, values after a clk edge with rst=1:
  - empty=1, full=0, count=0, ovf=udf=0, ram_wen=ram_ren=0.
  - Pointers, occupancy, in-flight stages and the prefetch buffer are cleared.
  - rd_data is held at 0.
  - RAM contents are not cleared.
- Reset mid-operation: ram_q from reads issued before reset is discarded, because the in-flight stages are cleared. Post-reset data is never corrupted.

Decomposition:
- Package shfifo_pkg holds:
  - RAM_RD_LAT=2 and PF_DEPTH=3 constants.
  - a pointer-difference helper function.
- Sub-module shfifo_pf_buf: 3-entry register FIFO with push/pop/head/cnt, used as the prefetch buffer.
- The top level instantiates shfifo_ctrl and sdp_ram side by side.

Test Plan:
- Single word: after reset, push 0xA5A5_0001 at cycle 0 -> empty falls in cycle 4, rd_data=0xA5A5_0001, count=1. Pop -> empty=1, count=0.
- Fill: push 0..10 with no pops -> full=1 after 11 accepted pushes (8 RAM + 3 prefetch), count=11. 12th push -> ovf pulse and count unchanged. Drain -> words 0..10 in order.
- Streaming: push and pop every cycle for 100 words -> no bubbles after the first word, in-order data, count constant, no ovf/udf.
- Wrap-around: 3 repeated fill/drain cycles of 8 words -> pointers wrap and the data matches the scoreboard.
- Underflow: rd_en while empty -> udf pulses for one cycle, and count and rd_data are unchanged.
- Mid-operation reset: rst during a burst with reads in flight -> empty=1, count=0. Next push of 0x1234 -> rd_data=0x1234, with no stale word delivered.
